// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the 5-stage RV32 pipeline hazard/sequencing controller.
package pipeline_ctrl_pkg;

  // Register file address width (x0..x31).
  localparam int REG_AW = 5;

  // EX operand source selects.
  localparam logic [1:0] FWD_REGFILE = 2'd0;
  localparam logic [1:0] FWD_MEM     = 2'd1;
  localparam logic [1:0] FWD_WB      = 2'd2;

  // Data-memory sequencing states.
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller: stalls, flushes, EX forwarding selects,
// post-redirect fetch kill, data-memory wait FSM and a saturating stall counter.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              id_valid,
  input  logic              id_rs1_read,
  input  logic              id_rs2_read,
  input  logic [REG_AW-1:0] id_rs1_addr,
  input  logic [REG_AW-1:0] id_rs2_addr,
  input  logic              ex_valid,
  input  logic              ex_rs1_read,
  input  logic              ex_rs2_read,
  input  logic [REG_AW-1:0] ex_rs1_addr,
  input  logic [REG_AW-1:0] ex_rs2_addr,
  input  logic              ex_rd_write,
  input  logic [REG_AW-1:0] ex_rd_addr,
  input  logic              ex_mem_read,
  input  logic              ex_redirect,
  input  logic              mem_valid,
  input  logic              mem_rd_write,
  input  logic [REG_AW-1:0] mem_rd_addr,
  input  logic              mem_req,
  input  logic              mem_ready,
  input  logic              wb_valid,
  input  logic              wb_rd_write,
  input  logic [REG_AW-1:0] wb_rd_addr,
  output logic              if_stall,
  output logic              id_stall,
  output logic              ex_stall,
  output logic              mem_stall,
  output logic              id_flush,
  output logic              ex_flush,
  output logic              wb_flush,
  output logic              if_kill,
  output logic [1:0]        fwd_rs1_sel,
  output logic [1:0]        fwd_rs2_sel,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [REG_AW-1:0] REG_X0 = {REG_AW{1'b0}};

  // Select the newest in-flight producer of an EX source; MEM is younger than WB.
  function automatic logic [1:0] fwd_sel(
    input logic              use_src,
    input logic [REG_AW-1:0] src,
    input logic              mem_prod,
    input logic [REG_AW-1:0] mem_rd,
    input logic              wb_prod,
    input logic [REG_AW-1:0] wb_rd
  );
    logic [1:0] sel;
    if (use_src && mem_prod && (mem_rd == src)) begin
      sel = FWD_MEM;
    end else if (use_src && wb_prod && (wb_rd == src)) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_REGFILE;
    end
    return sel;
  endfunction

  state_e           state_q, state_d;
  logic             if_kill_q, if_kill_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic ex_prod_s, mem_prod_s, wb_prod_s;
  logic id_uses_ex_rd_s;
  logic mem_hold_s, redirect_s, load_use_s;

  // Hazard qualification, priority resolution and next-state computation.
  always_comb begin
    ex_prod_s  = ex_valid  && ex_rd_write  && (ex_rd_addr  != REG_X0);
    mem_prod_s = mem_valid && mem_rd_write && (mem_rd_addr != REG_X0);
    wb_prod_s  = wb_valid  && wb_rd_write  && (wb_rd_addr  != REG_X0);

    id_uses_ex_rd_s = (id_valid && id_rs1_read && (id_rs1_addr == ex_rd_addr)) ||
                      (id_valid && id_rs2_read && (id_rs2_addr == ex_rd_addr));

    // A memory-held cycle is either a fresh miss in RUN or any non-ready WAIT cycle;
    // in WAIT the release is combinational on mem_ready.
    mem_hold_s = 1'b0;
    state_d    = state_q;
    case (state_q)
      ST_RUN: begin
        if (mem_req && mem_valid && !mem_ready) begin
          mem_hold_s = 1'b1;
          state_d    = ST_WAIT;
        end else begin
          mem_hold_s = 1'b0;
          state_d    = ST_RUN;
        end
      end
      ST_WAIT: begin
        if (mem_ready) begin
          mem_hold_s = 1'b0;
          state_d    = ST_RUN;
        end else begin
          mem_hold_s = 1'b1;
          state_d    = ST_WAIT;
        end
      end
      default: begin
        mem_hold_s = 1'b0;
        state_d    = ST_RUN;
      end
    endcase

    // Memory wait suppresses redirect; redirect suppresses load-use.
    redirect_s = ex_redirect && ex_valid && !mem_hold_s;
    load_use_s = ex_mem_read && ex_prod_s && id_uses_ex_rd_s && !mem_hold_s && !redirect_s;

    if_stall  = mem_hold_s || load_use_s;
    id_stall  = mem_hold_s || load_use_s;
    ex_stall  = mem_hold_s;
    mem_stall = mem_hold_s;
    wb_flush  = mem_hold_s;
    id_flush  = redirect_s;
    ex_flush  = redirect_s || load_use_s;

    fwd_rs1_sel = fwd_sel(ex_valid && ex_rs1_read, ex_rs1_addr,
                          mem_prod_s, mem_rd_addr, wb_prod_s, wb_rd_addr);
    fwd_rs2_sel = fwd_sel(ex_valid && ex_rs2_read, ex_rs2_addr,
                          mem_prod_s, mem_rd_addr, wb_prod_s, wb_rd_addr);

    // Kill the fetch returning after a redirect; keep it armed across memory stalls.
    if (redirect_s) begin
      if_kill_d = 1'b1;
    end else if (if_kill_q && mem_hold_s) begin
      if_kill_d = 1'b1;
    end else begin
      if_kill_d = 1'b0;
    end

    if (if_stall && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // FSM state, fetch-kill flag and stall counter registers.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q     <= ST_RUN;
      if_kill_q   <= 1'b0;
      stall_cnt_q <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      if_kill_q   <= if_kill_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign if_kill   = if_kill_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: a behavioural model checks every cycle,
// directed scenarios add hand-computed literal expectations.
module tb_pipeline_ctrl;

  logic       clk;
  logic       rst_b;
  logic       id_valid, id_rs1_read, id_rs2_read;
  logic [4:0] id_rs1_addr, id_rs2_addr;
  logic       ex_valid, ex_rs1_read, ex_rs2_read;
  logic [4:0] ex_rs1_addr, ex_rs2_addr;
  logic       ex_rd_write;
  logic [4:0] ex_rd_addr;
  logic       ex_mem_read, ex_redirect;
  logic       mem_valid, mem_rd_write;
  logic [4:0] mem_rd_addr;
  logic       mem_req, mem_ready;
  logic       wb_valid, wb_rd_write;
  logic [4:0] wb_rd_addr;

  logic        if_stall, id_stall, ex_stall, mem_stall;
  logic        id_flush, ex_flush, wb_flush, if_kill;
  logic [1:0]  fwd_rs1_sel, fwd_rs2_sel;
  logic [31:0] stall_cnt;

  logic        if_stall2, id_stall2, ex_stall2, mem_stall2;
  logic        id_flush2, ex_flush2, wb_flush2, if_kill2;
  logic [1:0]  fwd_rs1_sel2, fwd_rs2_sel2;
  logic [1:0]  stall_cnt2;

  int errors = 0;
  int checks = 0;

  // Behavioural model state: access outstanding, kill pending, stall-cycle totals.
  bit     m_wait;
  bit     m_kill;
  longint m_cnt;
  longint m_cnt2;

  pipeline_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst_b(rst_b),
    .id_valid(id_valid), .id_rs1_read(id_rs1_read), .id_rs2_read(id_rs2_read),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .ex_valid(ex_valid), .ex_rs1_read(ex_rs1_read), .ex_rs2_read(ex_rs2_read),
    .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr),
    .ex_rd_write(ex_rd_write), .ex_rd_addr(ex_rd_addr),
    .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect),
    .mem_valid(mem_valid), .mem_rd_write(mem_rd_write), .mem_rd_addr(mem_rd_addr),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .wb_valid(wb_valid), .wb_rd_write(wb_rd_write), .wb_rd_addr(wb_rd_addr),
    .if_stall(if_stall), .id_stall(id_stall), .ex_stall(ex_stall), .mem_stall(mem_stall),
    .id_flush(id_flush), .ex_flush(ex_flush), .wb_flush(wb_flush), .if_kill(if_kill),
    .fwd_rs1_sel(fwd_rs1_sel), .fwd_rs2_sel(fwd_rs2_sel), .stall_cnt(stall_cnt)
  );

  pipeline_ctrl #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_b(rst_b),
    .id_valid(id_valid), .id_rs1_read(id_rs1_read), .id_rs2_read(id_rs2_read),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .ex_valid(ex_valid), .ex_rs1_read(ex_rs1_read), .ex_rs2_read(ex_rs2_read),
    .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr),
    .ex_rd_write(ex_rd_write), .ex_rd_addr(ex_rd_addr),
    .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect),
    .mem_valid(mem_valid), .mem_rd_write(mem_rd_write), .mem_rd_addr(mem_rd_addr),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .wb_valid(wb_valid), .wb_rd_write(wb_rd_write), .wb_rd_addr(wb_rd_addr),
    .if_stall(if_stall2), .id_stall(id_stall2), .ex_stall(ex_stall2), .mem_stall(mem_stall2),
    .id_flush(id_flush2), .ex_flush(ex_flush2), .wb_flush(wb_flush2), .if_kill(if_kill2),
    .fwd_rs1_sel(fwd_rs1_sel2), .fwd_rs2_sel(fwd_rs2_sel2), .stall_cnt(stall_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_fwd(input bit use_src, input int src);
    if (use_src && mem_valid && mem_rd_write && mem_rd_addr != 0 && int'(mem_rd_addr) == src)
      return 1;
    if (use_src && wb_valid && wb_rd_write && wb_rd_addr != 0 && int'(wb_rd_addr) == src)
      return 2;
    return 0;
  endfunction

  // Compare every DUT output against the model for the current cycle, then advance the model.
  task automatic model_cycle();
    bit st_wait, kill, hold, redir, lu, uses, stall;
    longint c, c2;
    st_wait = rst_b ? m_wait : 1'b0;
    kill    = rst_b ? m_kill : 1'b0;
    c       = rst_b ? m_cnt  : 0;
    c2      = rst_b ? m_cnt2 : 0;
    hold  = st_wait ? !mem_ready : (mem_req && mem_valid && !mem_ready);
    redir = ex_redirect && ex_valid && !hold;
    uses  = (id_valid && id_rs1_read && id_rs1_addr == ex_rd_addr) ||
            (id_valid && id_rs2_read && id_rs2_addr == ex_rd_addr);
    lu    = ex_mem_read && ex_valid && ex_rd_write && ex_rd_addr != 0 && uses && !hold && !redir;
    stall = hold || lu;
    check("if_stall",  if_stall,  stall);
    check("id_stall",  id_stall,  stall);
    check("ex_stall",  ex_stall,  hold);
    check("mem_stall", mem_stall, hold);
    check("wb_flush",  wb_flush,  hold);
    check("id_flush",  id_flush,  redir);
    check("ex_flush",  ex_flush,  redir || lu);
    check("if_kill",   if_kill,   kill);
    check("fwd_rs1",   fwd_rs1_sel, model_fwd(ex_valid && ex_rs1_read, int'(ex_rs1_addr)));
    check("fwd_rs2",   fwd_rs2_sel, model_fwd(ex_valid && ex_rs2_read, int'(ex_rs2_addr)));
    check("stall_cnt", stall_cnt, c);
    check("if_stall_w2", if_stall2, stall);
    check("ex_flush_w2", ex_flush2, redir || lu);
    check("if_kill_w2",  if_kill2,  kill);
    check("fwd_w2", {fwd_rs1_sel2, fwd_rs2_sel2} == {fwd_rs1_sel, fwd_rs2_sel} &&
          id_stall2 == stall && ex_stall2 == hold && mem_stall2 == hold &&
          wb_flush2 == hold && id_flush2 == redir, 1);
    check("stall_cnt_w2", stall_cnt2, c2);
    if (!rst_b) begin
      m_wait = 1'b0; m_kill = 1'b0; m_cnt = 0; m_cnt2 = 0;
    end else begin
      m_wait = hold;
      m_kill = redir || (kill && hold);
      m_cnt  = (stall && c  < 64'hFFFF_FFFF) ? c + 1  : c;
      m_cnt2 = (stall && c2 < 3)             ? c2 + 1 : c2;
    end
  endtask

  task automatic sample();
    @(negedge clk);
    model_cycle();
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_valid = 0; id_rs1_read = 0; id_rs2_read = 0; id_rs1_addr = 0; id_rs2_addr = 0;
    ex_valid = 0; ex_rs1_read = 0; ex_rs2_read = 0; ex_rs1_addr = 0; ex_rs2_addr = 0;
    ex_rd_write = 0; ex_rd_addr = 0; ex_mem_read = 0; ex_redirect = 0;
    mem_valid = 0; mem_rd_write = 0; mem_rd_addr = 0; mem_req = 0; mem_ready = 0;
    wb_valid = 0; wb_rd_write = 0; wb_rd_addr = 0;
  endtask

  longint cnt0;

  initial begin
    m_wait = 0; m_kill = 0; m_cnt = 0; m_cnt2 = 0;
    idle_inputs();
    rst_b = 1'b0;

    // Reset state.
    sample();
    check("rst_cnt", stall_cnt, 0);
    check("rst_kill", if_kill, 0);
    check("rst_outs", {if_stall, id_stall, ex_stall, mem_stall, id_flush, ex_flush, wb_flush,
                       fwd_rs1_sel, fwd_rs2_sel}, 0);
    advance();
    rst_b = 1'b1;
    sample(); advance();

    // Forwarding priority.
    mem_valid = 1; mem_rd_write = 1; mem_rd_addr = 5;
    wb_valid = 1; wb_rd_write = 1; wb_rd_addr = 5;
    ex_valid = 1; ex_rs1_read = 1; ex_rs1_addr = 5; ex_rs2_read = 1; ex_rs2_addr = 6;
    sample();
    check("fwd_mem_prio", fwd_rs1_sel, 1);
    check("fwd_rs2_none", fwd_rs2_sel, 0);
    advance();
    mem_rd_write = 0;
    sample();
    check("fwd_wb", fwd_rs1_sel, 2);
    advance();
    mem_rd_write = 1; mem_rd_addr = 0; wb_rd_addr = 0;
    sample();
    check("fwd_x0", fwd_rs1_sel, 0);
    advance();
    mem_rd_addr = 9; wb_rd_addr = 6; ex_rs1_addr = 9;
    sample();
    check("fwd_split", {fwd_rs1_sel, fwd_rs2_sel}, 4'b0110);
    advance();

    // Load-use: lw x7 in EX, add x8,x7,x1 in ID.
    idle_inputs();
    ex_valid = 1; ex_rd_write = 1; ex_rd_addr = 7; ex_mem_read = 1;
    id_valid = 1; id_rs1_read = 1; id_rs1_addr = 7; id_rs2_read = 1; id_rs2_addr = 1;
    cnt0 = longint'(stall_cnt);
    sample();
    check("lu_stall", {if_stall, id_stall, ex_flush, ex_stall}, 4'b1110);
    advance();
    ex_mem_read = 0;
    sample();
    check("lu_release", if_stall, 0);
    check("lu_cnt", stall_cnt, cnt0 + 1);
    advance();

    // Redirect pulse, then redirect combined with a load-use.
    idle_inputs();
    ex_valid = 1; ex_redirect = 1;
    sample();
    check("redir_flush", {id_flush, ex_flush, if_kill}, 3'b110);
    advance();
    ex_redirect = 0;
    sample();
    check("redir_kill", if_kill, 1);
    advance();
    sample();
    check("redir_kill_once", if_kill, 0);
    advance();
    ex_redirect = 1; ex_rd_write = 1; ex_rd_addr = 3; ex_mem_read = 1;
    id_valid = 1; id_rs1_read = 1; id_rs1_addr = 3;
    sample();
    check("redir_over_lu", {if_stall, id_flush, ex_flush}, 3'b011);
    advance();

    // Memory wait: ready low for 3 cycles.
    idle_inputs();
    sample(); advance();
    mem_valid = 1; mem_req = 1; mem_ready = 0;
    cnt0 = longint'(stall_cnt);
    for (int i = 0; i < 3; i++) begin
      sample();
      check("mw_stalls", {if_stall, id_stall, ex_stall, mem_stall, wb_flush}, 5'b11111);
      advance();
    end
    mem_ready = 1;
    sample();
    check("mw_release", {if_stall, ex_stall, wb_flush}, 0);
    check("mw_cnt", stall_cnt, cnt0 + 3);
    advance();

    // Zero-wait access never stalls.
    sample();
    check("zero_wait", if_stall, 0);
    advance();

    // Redirect held through a 2-cycle wait.
    idle_inputs();
    mem_valid = 1; mem_req = 1; mem_ready = 0; ex_valid = 1; ex_redirect = 1;
    for (int i = 0; i < 2; i++) begin
      sample();
      check("rw_noflush", {id_flush, ex_flush, if_stall}, 3'b001);
      advance();
    end
    mem_ready = 1;
    sample();
    check("rw_flush", {id_flush, ex_flush, if_kill}, 3'b110);
    advance();
    idle_inputs();
    sample();
    check("rw_kill", if_kill, 1);
    advance();

    // if_kill held while the cycle after the redirect is memory-stalled.
    ex_valid = 1; ex_redirect = 1;
    sample(); advance();
    idle_inputs();
    mem_valid = 1; mem_req = 1; mem_ready = 0;
    sample();
    check("kill_in_stall", {if_kill, if_stall}, 2'b11);
    advance();
    mem_ready = 1;
    sample();
    check("kill_held", {if_kill, if_stall}, 2'b10);
    advance();
    idle_inputs();
    sample();
    check("kill_drop", if_kill, 0);
    advance();

    // Reset asserted mid-WAIT.
    mem_valid = 1; mem_req = 1; mem_ready = 0;
    sample(); advance();
    sample();
    #2;
    idle_inputs();
    rst_b = 1'b0;
    #1;
    check("async_rst_cnt", stall_cnt, 0);
    check("async_rst_cnt2", stall_cnt2, 0);
    check("async_rst_outs", {if_stall, id_stall, ex_stall, mem_stall, wb_flush, if_kill}, 0);
    advance();
    sample();
    advance();
    rst_b = 1'b1;
    sample(); advance();

    // Saturation of the 2-bit counter over 5 stalled cycles.
    mem_valid = 1; mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 5; i++) begin
      sample(); advance();
    end
    mem_ready = 1;
    sample();
    check("sat_cnt2", stall_cnt2, 3);
    check("sat_cnt32", stall_cnt, 5);
    advance();
    idle_inputs();
    sample(); advance();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
